// File: rtl/spi_master.sv
// SPI mode-0 master: one byte per transfer, CLK_DIV clk cycles per SCLK half-period.
// Ports: start/tx_data in, rx_data/busy/done out, sclk/mosi/ss_n/miso SPI. Macro: SPI_MASTER_LSB_FIRST_EN.
module spi_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       done,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso,
  output logic       ss_n
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_ONE = DW'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    XFER   = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [3:0]    tog_q, tog_d;
  logic          sclk_q, sclk_d;
  logic [7:0]    tx_sh_q, tx_sh_d;
  logic [7:0]    rx_sh_q, rx_sh_d;
  logic [7:0]    rx_data_q, rx_data_d;

  logic       tx_bit;
  logic [7:0] tx_next;
  logic [7:0] rx_next;

`ifdef SPI_MASTER_LSB_FIRST_EN
  assign tx_bit  = tx_sh_q[0];
  assign tx_next = {1'b0, tx_sh_q[7:1]};
  assign rx_next = {miso, rx_sh_q[7:1]};
`else
  assign tx_bit  = tx_sh_q[7];
  assign tx_next = {tx_sh_q[6:0], 1'b0};
  assign rx_next = {rx_sh_q[6:0], miso};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      div_q     <= '0;
      tog_q     <= '0;
      sclk_q    <= 1'b0;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      tog_q     <= tog_d;
      sclk_q    <= sclk_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    tog_d     = tog_q;
    sclk_d    = sclk_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = XFER;
          tx_sh_d = tx_data;
          rx_sh_d = '0;
          div_d   = '0;
          tog_d   = '0;
          sclk_d  = 1'b0;
        end
      end
      XFER: begin
        if (div_q == DIV_MAX) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          tog_d  = tog_q + 4'd1;
          if (!sclk_q) begin
            rx_sh_d = rx_next;
          end else if (tog_q != 4'd15) begin
            // last falling edge leaves mosi alone; FINISH gates it to 0
            tx_sh_d = tx_next;
          end
          if (tog_q == 4'd15) begin
            state_d   = FINISH;
            rx_data_d = rx_sh_q;
          end
        end else begin
          div_d = div_q + DIV_ONE;
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    ss_n    = 1'b1;
    mosi    = 1'b0;
    sclk    = sclk_q;
    rx_data = rx_data_q;
    unique case (state_q)
      XFER: begin
        busy = 1'b1;
        ss_n = 1'b0;
        mosi = tx_bit;
      end
      FINISH: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_spi_master.sv
// Randomized self-checking bench for spi_master with a mode-0 slave model.
// Checks data, frame timing, start filtering and async reset abort.
module tb_spi_master;

  localparam int CLK_DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] tx_data = '0;
  logic [7:0] rx_data;
  logic       busy;
  logic       done;
  logic       sclk;
  logic       mosi;
  logic       miso = 1'b0;
  logic       ss_n;

  int n_tests = 0;
  int n_fail  = 0;

  spi_master #(.CLK_DIV(CLK_DIV)) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .tx_data(tx_data),
    .rx_data(rx_data),
    .busy   (busy),
    .done   (done),
    .sclk   (sclk),
    .mosi   (mosi),
    .miso   (miso),
    .ss_n   (ss_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // bit position sent/received as the i-th bit on the wire
  function automatic int pos(input int i);
`ifdef SPI_MASTER_LSB_FIRST_EN
    return i;
`else
    return 7 - i;
`endif
  endfunction

  // mode-0 slave: first bit ready at ss_n fall, capture on rise, shift on fall
  logic [7:0] sl_tx = '0;
  logic [7:0] sl_rx = '0;
  int         sl_idx = 0;
  int         sl_rx_n = 0;
  logic       sl_ss_prev = 1'b1;
  logic       sl_sclk_prev = 1'b0;

  always @(ss_n, sclk) begin
    if (sl_ss_prev === 1'b1 && ss_n === 1'b0) begin
      sl_idx  = 0;
      sl_rx_n = 0;
      sl_rx   = '0;
      miso    = sl_tx[pos(0)];
    end else if (ss_n === 1'b0 && sclk === 1'b1 && sl_sclk_prev === 1'b0) begin
      if (sl_rx_n < 8) sl_rx[pos(sl_rx_n)] = mosi;
      sl_rx_n++;
    end else if (ss_n === 1'b0 && sclk === 1'b0 && sl_sclk_prev === 1'b1) begin
      sl_idx++;
      if (sl_idx < 8) miso = sl_tx[pos(sl_idx)];
    end
    sl_ss_prev   = ss_n;
    sl_sclk_prev = sclk;
  end

  // event counters sampled mid-cycle
  int   ss_low_cnt = 0;
  int   done_cnt = 0;
  int   rise_cnt = 0;
  int   tg_cnt = 0;
  logic m_sclk_prev = 1'b0;
  logic m_ss_prev = 1'b1;

  always @(negedge clk) begin
    if (ss_n === 1'b0) ss_low_cnt++;
    if (done === 1'b1) done_cnt++;
    if (sclk === 1'b1 && m_sclk_prev === 1'b0) rise_cnt++;
    if (sclk !== m_sclk_prev) tg_cnt++;
    if (rst_n && ss_n !== m_ss_prev && m_ss_prev !== 1'bx)
      check("sclk_at_ss_edge", {31'd0, sclk}, 32'd0);
    m_sclk_prev = sclk;
    m_ss_prev   = ss_n;
  end

  // one transfer, starting at a negedge while the DUT is idle
  task automatic xfer(input logic [7:0] tx, input logic [7:0] sl,
                      input bit glitch, input bit fin_start);
    int  n;
    int  d0, s0, r0;
    bit  seen;
    sl_tx   = sl;
    d0      = done_cnt;
    s0      = ss_low_cnt;
    r0      = rise_cnt;
    start   = 1'b1;
    tx_data = tx;
    @(negedge clk);
    start   = 1'b0;
    tx_data = 8'($urandom);
    n = 1;
    check("busy_on_accept", {31'd0, busy}, 32'd1);
    check("first_mosi", {31'd0, mosi}, {31'd0, tx[pos(0)]});
    seen = 0;
    while (n < 300) begin
      if (done === 1'b1) begin
        seen = 1;
        break;
      end
      if (glitch && n == 20) begin
        start   = 1'b1;
        tx_data = 8'hFF;
      end
      if (glitch && n == 21) start = 1'b0;
      @(negedge clk);
      n++;
    end
    check("done_seen", {31'd0, seen}, 32'd1);
    check("latency", n, 16 * CLK_DIV + 1);
    check("rx_data", {24'd0, rx_data}, {24'd0, sl});
    check("slave_rx", {24'd0, sl_rx}, {24'd0, tx});
    check("ss_n_finish", {31'd0, ss_n}, 32'd1);
    check("busy_finish", {31'd0, busy}, 32'd0);
    if (fin_start) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_ss_n", {31'd0, ss_n}, 32'd1);
    check("idle_done", {31'd0, done}, 32'd0);
    check("done_pulses", done_cnt - d0, 1);
    check("ss_low_cycles", ss_low_cnt - s0, 16 * CLK_DIV);
    check("sclk_rises", rise_cnt - r0, 8);
  endtask

  task automatic reset_abort();
    int t0, d0, k;
    sl_tx   = 8'hC3;
    start   = 1'b1;
    tx_data = 8'h3C;
    @(negedge clk);
    start = 1'b0;
    #1;
    t0 = tg_cnt;
    d0 = done_cnt;
    k  = 0;
    while (tg_cnt - t0 < 5 && k < 300) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("reach_edge5", {31'd0, (tg_cnt - t0 >= 5)}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_ss_n", {31'd0, ss_n}, 32'd1);
    check("rst_sclk", {31'd0, sclk}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_mosi", {31'd0, mosi}, 32'd0);
    check("rst_rx_data", {24'd0, rx_data}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("rst_no_done", done_cnt - d0, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a, b;
    repeat (3) @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_ss_n", {31'd0, ss_n}, 32'd1);
    check("reset_sclk", {31'd0, sclk}, 32'd0);
    check("reset_mosi", {31'd0, mosi}, 32'd0);
    check("reset_rx", {24'd0, rx_data}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    xfer(8'h3C, 8'hA5, 1'b0, 1'b0);
    xfer(8'h55, 8'hBB, 1'b0, 1'b1);
    xfer(8'hF0, 8'h0F, 1'b0, 1'b0);
    xfer(8'h3C, 8'hA5, 1'b1, 1'b0);
    reset_abort();
    xfer(8'h3C, 8'hA5, 1'b0, 1'b0);
    xfer(8'h01, 8'h80, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      xfer(a, b, 1'($urandom), 1'($urandom));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter CLK_DIV, default 4, clk cycles per SCLK half-period; legal values are integers >= 1.
REQ-002 clk  input  1  sole clock; all logic on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  transfer request, sampled on rising clk.
REQ-005 tx_data  input  8  byte to send on mosi.
REQ-006 rx_data  output  8  byte received on miso, registered.
REQ-007 busy  output  1  high while a transfer is in progress.
REQ-008 done  output  1  one-cycle completion pulse.
REQ-009 sclk  output  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
REQ-010 mosi  output  1  serial data to slave.
REQ-011 miso  input  1  serial data from slave.
REQ-012 ss_n  output  1  active-low slave select.

Function
REQ-013 States are IDLE, XFER and FINISH; the module powers up in IDLE via reset.
REQ-014 In IDLE with start=1 at a clk edge: latch tx_data into the shift register, set busy=1, drive ss_n=0 and mosi=bit7, clear the divider, and enter XFER.
REQ-015 start is ignored while busy=1; tx_data changes after acceptance have no effect.
REQ-016 In XFER, sclk toggles every CLK_DIV clk cycles, giving exactly 16 toggles (8 rising, 8 falling edges) and ss_n low for 16*CLK_DIV cycles.
REQ-017 On the clk edge that raises sclk, miso is shifted into the receive register, MSB first.
REQ-018 On the clk edge that lowers sclk after bits 1..7, mosi advances to the next lower bit; mosi is stable for a full SCLK period around each rising edge.
REQ-019 On the 16th toggle (sclk returns to 0), the module enters FINISH.
REQ-020 In FINISH (one cycle): ss_n=1, busy=0, done=1, rx_data loaded with the 8 received bits; next state is IDLE.
REQ-021 done is high for exactly one cycle per transfer and never otherwise.
REQ-022 rx_data holds its value until the next transfer completes.
REQ-023 In IDLE: sclk=0, ss_n=1, mosi=0, busy=0, done=0.
REQ-024 start=1 in the FINISH cycle is ignored; the earliest new acceptance is the following IDLE cycle, so ss_n stays high for at least one cycle between transfers.
REQ-025 Start-to-done latency is 16*CLK_DIV+1 cycles from the accepting edge.

Reset
REQ-026 While rst_n=0, asynchronously: state=IDLE, sclk=0, ss_n=1, mosi=0, busy=0, done=0, rx_data=8'h00, divider and shift registers cleared.
REQ-027 Reset asserted mid-transfer aborts immediately with no done pulse; rx_data returns to 8'h00.

Configuration
REQ-028 Macro SPI_MASTER_LSB_FIRST_EN: when defined, the first bit is tx_data[0] on mosi and the first miso bit lands in rx_data[0] (LSB first); when undefined, the module is MSB first as in REQ-014 to REQ-018. Timing is identical in both builds.

Verification
REQ-029 CLK_DIV=4, mode-0 slave loopback model: tx_data=0x3C, slave sends 0xA5 -> rx_data=0xA5, slave receives 0x3C, one done pulse.
REQ-030 Back-to-back transfers 0x55/0xBB then 0xF0/0x0F -> rx_data=0xBB then 0x0F; slave receives 0x55 then 0xF0.
REQ-031 CLK_DIV=4 timing: ss_n low for exactly 64 cycles, 8 sclk rising edges, done exactly 65 cycles after the accepting edge, sclk=0 at both ss_n edges.
REQ-032 start pulsed again mid-transfer with tx_data=0xFF -> ignored; current byte completes unchanged; single done pulse.
REQ-033 rst_n dropped at sclk edge 5 -> ss_n=1, sclk=0, busy=0, rx_data=0x00 immediately; no done pulse; the next transfer 0x3C/0xA5 passes.
REQ-034 With SPI_MASTER_LSB_FIRST_EN defined: tx_data=0x01 -> first mosi bit is 1; LSB-first slave sends 0x80 -> rx_data=0x80.
